// File: rtl/day_pkg.sv
// Shared types and widths for the day/month calendar counter.
package day_pkg;
  localparam int DAY_MIN = 1;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  typedef enum logic [1:0] {
    EMPTY,
    RUN,
    BUSY
  } state_t;
endpackage

// File: rtl/day_counter_if.sv
// Load/tick request bus and date outputs of the day counter.
interface day_counter_if;
  import day_pkg::*;

  logic               tick;
  logic               load_valid;
  logic [DAY_W-1:0]   load_day;
  logic               load_ready;
  logic [DAY_W-1:0]   today;
  logic [MONTH_W-1:0] month;
  logic               today_valid;
  logic               load_err;
  logic               month_wrap;
  logic               year_wrap;

  modport master (
    output tick, load_valid, load_day,
    input  load_ready, today, month, today_valid, load_err, month_wrap, year_wrap
  );

  modport slave (
    input  tick, load_valid, load_day,
    output load_ready, today, month, today_valid, load_err, month_wrap, year_wrap
  );
endinterface

// File: rtl/wrap_counter.sv
// Counter running DAY_MIN..MAX with synchronous load; wrap_o flags the step from MAX back to DAY_MIN.
module wrap_counter
  import day_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int MAX   = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             atMax;

  assign atMax = (count_q == WIDTH'(MAX));

  // Load has priority over counting, so a wrap can never coincide with a load.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (en_i) begin
      count_d = atMax ? WIDTH'(DAY_MIN) : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= WIDTH'(DAY_MIN);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = en_i && !load_i && atMax;

endmodule

// File: rtl/day_counter.sv
// Calendar day/month counter with a load handshake; all outputs registered.
module day_counter
  import day_pkg::*;
#(
  parameter int DAYS_PER_MONTH = 30,
  parameter int MONTHS         = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  day_counter_if.slave bus
);

  state_t state_q;
  logic   loadReady_q, todayValid_q, loadErr_q, monthWrap_q, yearWrap_q;
  logic   accept, legal, dayLoad, dayEn, dayWrap, monthWrap;
  logic [DAY_W-1:0]   dayCount;
  logic [MONTH_W-1:0] monthCount;

  assign accept  = bus.load_valid && loadReady_q;
  assign legal   = (bus.load_day >= DAY_W'(DAY_MIN)) && (bus.load_day <= DAY_W'(DAYS_PER_MONTH));
  assign dayLoad = accept && legal;
  // Any accepted load, legal or not, swallows a simultaneous tick.
  assign dayEn   = bus.tick && (state_q == RUN) && !accept;

  wrap_counter #(.WIDTH(DAY_W), .MAX(DAYS_PER_MONTH)) uDay (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (dayEn),
    .load_i      (dayLoad),
    .loadValue_i (bus.load_day),
    .count_o     (dayCount),
    .wrap_o      (dayWrap)
  );

  wrap_counter #(.WIDTH(MONTH_W), .MAX(MONTHS)) uMonth (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (dayWrap),
    .load_i      (1'b0),
    .loadValue_i (MONTH_W'(DAY_MIN)),
    .count_o     (monthCount),
    .wrap_o      (monthWrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      loadReady_q  <= 1'b1;
      todayValid_q <= 1'b0;
      loadErr_q    <= 1'b0;
      monthWrap_q  <= 1'b0;
      yearWrap_q   <= 1'b0;
    end else begin
      loadErr_q   <= accept && !legal;
      monthWrap_q <= dayWrap;
      yearWrap_q  <= monthWrap;
      case (state_q)
        EMPTY, RUN: begin
          if (dayLoad) begin
            state_q      <= BUSY;
            loadReady_q  <= 1'b0;
            todayValid_q <= 1'b1;
          end
        end
        BUSY: begin
          state_q      <= RUN;
          loadReady_q  <= 1'b1;
          todayValid_q <= 1'b1;
        end
        default: begin
          state_q      <= EMPTY;
          loadReady_q  <= 1'b1;
          todayValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready  = loadReady_q;
  assign bus.today       = dayCount;
  assign bus.month       = monthCount;
  assign bus.today_valid = todayValid_q;
  assign bus.load_err    = loadErr_q;
  assign bus.month_wrap  = monthWrap_q;
  assign bus.year_wrap   = yearWrap_q;

endmodule

// File: tb/tb_day_counter.sv
// Scoreboarded bench for day_counter: a calendar model predicts every cycle, a monitor compares.
module tb_day_counter;
  localparam int DPM = 30;
  localparam int NMON = 12;

  typedef struct {
    int loadReady;
    int today;
    int month;
    int todayValid;
    int loadErr;
    int monthWrap;
    int yearWrap;
  } expect_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  expect_t expQ[$];

  int modelHas, modelBusy, modelDay, modelMonth;

  day_counter_if bus ();

  day_counter #(.DAYS_PER_MONTH(DPM), .MONTHS(NMON)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".today"}, int'(bus.today), 1);
    checkOutput({tag, ".month"}, int'(bus.month), 1);
    checkOutput({tag, ".today_valid"}, int'(bus.today_valid), 0);
    checkOutput({tag, ".load_ready"}, int'(bus.load_ready), 1);
    checkOutput({tag, ".load_err"}, int'(bus.load_err), 0);
    checkOutput({tag, ".month_wrap"}, int'(bus.month_wrap), 0);
    checkOutput({tag, ".year_wrap"}, int'(bus.year_wrap), 0);
  endtask

  task automatic modelReset();
    modelHas = 0;
    modelBusy = 0;
    modelDay = 1;
    modelMonth = 1;
  endtask

  // Calendar treated as a linear day index across the year.
  task automatic modelStep(input int tick, input int lv, input int ld, output expect_t e);
    int idx;
    e.loadErr = 0;
    e.monthWrap = 0;
    e.yearWrap = 0;
    if (modelBusy != 0) begin
      modelBusy = 0;
    end else if (lv != 0) begin
      if (ld >= 1 && ld <= DPM) begin
        modelDay = ld;
        modelBusy = 1;
        modelHas = 1;
      end else begin
        e.loadErr = 1;
      end
    end else if (tick != 0 && modelHas != 0) begin
      idx = ((modelMonth - 1) * DPM + (modelDay - 1) + 1) % (DPM * NMON);
      modelDay = idx % DPM + 1;
      modelMonth = idx / DPM + 1;
      e.monthWrap = (modelDay == 1) ? 1 : 0;
      e.yearWrap = (modelDay == 1 && modelMonth == 1) ? 1 : 0;
    end
    e.loadReady = (modelBusy != 0) ? 0 : 1;
    e.todayValid = modelHas;
    e.today = modelDay;
    e.month = modelMonth;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input int tick, input int lv, input int ld);
    expect_t e;
    bus.tick = tick[0];
    bus.load_valid = lv[0];
    bus.load_day = ld[4:0];
    modelStep(tick, lv, ld, e);
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_day = 5'd0;
    #1;
    checkResetValues("reset");
    expQ.delete();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset pulse lands between edges while a day-wrap tick is pending.
  task automatic resetDuringTick();
    bus.tick = 1'b1;
    bus.load_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    bus.tick = 1'b0;
    expQ.delete();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("load_ready", int'(bus.load_ready), e.loadReady);
        checkOutput("today", int'(bus.today), e.today);
        checkOutput("month", int'(bus.month), e.month);
        checkOutput("today_valid", int'(bus.today_valid), e.todayValid);
        checkOutput("load_err", int'(bus.load_err), e.loadErr);
        checkOutput("month_wrap", int'(bus.month_wrap), e.monthWrap);
        checkOutput("year_wrap", int'(bus.year_wrap), e.yearWrap);
      end
    end
  end

  initial begin : driver
    int guard;
    bus.tick = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_day = 5'd0;
    modelReset();
    #2;
    applyReset();

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);

    applyStimulus(0, 1, 28);
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);

    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 31);
    applyStimulus(0, 0, 0);

    guard = 0;
    while (!(modelMonth == NMON && modelDay == DPM) && guard < 2000) begin
      applyStimulus(1, 0, 0);
      guard++;
    end
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    applyStimulus(0, 1, 10);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 5);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);

    applyStimulus(0, 1, 30);
    applyStimulus(0, 0, 0);
    resetDuringTick();
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);

    applyStimulus(0, 1, 3);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(int'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 1 : 0,
                    int'($urandom_range(0, 31)));
    end
    applyStimulus(0, 0, 0);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/day_counter.md
DAY_COUNTER -- requirements
Module: day_counter

Interface
REQ-001 Parameter: DAYS_PER_MONTH, default 30, last valid day of every month; legal range 28..30.
REQ-002 Parameter: MONTHS, default 12, number of months per year.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: tick  input  1  one-cycle request to advance one day.
REQ-006 Port: load_valid  input  1  load request.
REQ-007 Port: load_day  input  5  day value to load, unsigned.
REQ-008 Port: load_ready  output  1  load acceptance.
REQ-009 Port: today  output  5  current day of month, the 5-bit day code consumed by the day-after-tomorrow stage.
REQ-010 Port: month  output  4  current month, 1..MONTHS.
REQ-011 Port: today_valid  output  1  today/month hold a legal date.
REQ-012 Port: load_err  output  1  one-cycle pulse on a rejected load.
REQ-013 Port: month_wrap  output  1  one-cycle pulse when day wraps to 1.
REQ-014 Port: year_wrap  output  1  one-cycle pulse when month wraps to 1.

Function
REQ-015 FSM SHALL have states EMPTY (no legal date), RUN (counting), BUSY (one-cycle settle after an accepted load).
REQ-016 Handshake: load accepted when load_valid && load_ready at a rising edge.
REQ-017 load_ready SHALL be 1 in EMPTY and RUN and 0 in BUSY.
REQ-018 Legal load_day: 1..DAYS_PER_MONTH. Accepted legal load: today<=load_day next edge, month unchanged, go to BUSY.
REQ-019 Accepted illegal load (0 or >DAYS_PER_MONTH): today/month/state unchanged; load_err=1 for exactly the next cycle.
REQ-020 BUSY SHALL go to RUN unconditionally after one cycle; a tick arriving in BUSY is dropped.
REQ-021 tick in EMPTY SHALL be ignored; tick in RUN SHALL advance today by 1.
REQ-022 Day wrap: today==DAYS_PER_MONTH on tick -> today<=1, month<=month+1, month_wrap=1 for the next cycle.
REQ-023 Month wrap: month==MONTHS on day wrap -> month<=1, year_wrap=1 for the same cycle as month_wrap.
REQ-024 Simultaneous accepted load and tick: the load wins; the tick is dropped; no wrap pulses.
REQ-025 today_valid SHALL be 1 in RUN and BUSY and 0 in EMPTY.
REQ-026 Latency: outputs reflect a tick or load one clock after the sampling edge; all outputs are registered.
REQ-027 Invariant: in RUN, today ∈ 1..DAYS_PER_MONTH and month ∈ 1..MONTHS; today never equals 0 or 31.

Reset
REQ-028 rst_n low SHALL immediately force: state=EMPTY, today=1, month=1, today_valid=0, load_ready=1, load_err=0, month_wrap=0, year_wrap=0.
REQ-029 Reset asserted mid-load or mid-wrap SHALL abort the operation with no pulse emitted afterwards.
REQ-030 First edge after rst_n release SHALL sample inputs normally.

Structure
REQ-031 Shared package day_pkg SHALL hold: the state enum (EMPTY/RUN/BUSY), DAY_MIN=1, DAY_W=5, MONTH_W=4.
REQ-032 One sub-module, wrap_counter (parameterised width/max, enable, load, wrap pulse out), SHALL be instantiated twice: for the day and for the month.

Verification
REQ-033 Reset, then tick x3 with no load -> today=1, today_valid=0, no pulses.
REQ-034 Load 28 -> load_ready=0 for one cycle, today=28; then tick x3 -> 29, 30, 1 with month_wrap=1 on the last step, month=2.
REQ-035 Load 0, then load 31 -> load_err pulses each time; today, month and today_valid unchanged.
REQ-036 Month=12, today=30, tick -> today=1, month=1, month_wrap=1 and year_wrap=1 in the same cycle.
REQ-037 load_valid=1, load_day=5 and tick together in RUN with today=10 -> today=5, no wrap pulses; a tick in the following BUSY cycle is dropped.
REQ-038 rst_n pulsed low between two clock edges during a day-wrap tick -> outputs take reset values asynchronously, no month_wrap pulse after release.
